// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use interlock, branch flush, operand forwarding
// and a memory-wait watchdog that halts the pipe if data memory never answers.
module hazard_unit #(
    parameter int AWIDTH    = 5,
    parameter int CNT_WIDTH = 16,
    parameter int MAX_WAIT  = 15
) (
    input  logic                 hz_clk,
    input  logic                 hz_rst,
    input  logic                 hz_i_ce,
    input  logic [AWIDTH-1:0]    hz_i_de_rs1_addr,
    input  logic [AWIDTH-1:0]    hz_i_de_rs2_addr,
    input  logic                 hz_i_de_rs1_use,
    input  logic                 hz_i_de_rs2_use,
    input  logic [AWIDTH-1:0]    hz_i_ex_rd_addr,
    input  logic                 hz_i_ex_rd_we,
    input  logic                 hz_i_ex_load,
    input  logic [AWIDTH-1:0]    hz_i_mem_rd_addr,
    input  logic                 hz_i_mem_rd_we,
    input  logic [AWIDTH-1:0]    hz_i_wb_rd_addr,
    input  logic                 hz_i_wb_rd_we,
    input  logic                 hz_i_change_pc,
    input  logic                 hz_i_mem_req,
    input  logic                 hz_i_mem_ack,
    output logic                 hz_o_stall_fe,
    output logic                 hz_o_stall_de,
    output logic                 hz_o_stall_ex,
    output logic                 hz_o_stall_mem,
    output logic                 hz_o_flush_de,
    output logic                 hz_o_flush_ex,
    output logic [1:0]           hz_o_fwd_a,
    output logic [1:0]           hz_o_fwd_b,
    output logic                 hz_o_timeout,
    output logic [CNT_WIDTH-1:0] hz_o_stall_cnt
);

    localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_e;

    state_e               state_q, state_d;
    logic [WW-1:0]        wait_q, wait_d;
    logic                 pend_q, pend_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic       mem_stall, load_use, redirect;
    logic [3:0] stall_v;   // {fe, de, ex, mem}
    logic [1:0] flush_v;   // {de, ex}

    function automatic logic [1:0] fwd_sel(input logic [AWIDTH-1:0] a, input logic used);
        logic [1:0] sel;
        sel = 2'b00;
        if (used && a != '0) begin
            if (hz_i_ex_rd_we && !hz_i_ex_load && hz_i_ex_rd_addr == a)
                sel = 2'b01;
            else if (hz_i_mem_rd_we && hz_i_mem_rd_addr == a)
                sel = 2'b10;
            else if (hz_i_wb_rd_we && hz_i_wb_rd_addr == a)
                sel = 2'b11;
        end
        return sel;
    endfunction

    always_comb begin
        mem_stall = hz_i_mem_req && !hz_i_mem_ack && (state_q != HALT);
        load_use  = hz_i_ex_load && hz_i_ex_rd_we && (hz_i_ex_rd_addr != '0) &&
                    ((hz_i_de_rs1_use && hz_i_de_rs1_addr == hz_i_ex_rd_addr) ||
                     (hz_i_de_rs2_use && hz_i_de_rs2_addr == hz_i_ex_rd_addr));
        redirect  = hz_i_change_pc || pend_q;
    end

    always_ff @(posedge hz_clk or negedge hz_rst) begin
        if (!hz_rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        if (hz_i_ce) begin
            case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        state_d = MEM_WAIT;
                        wait_d  = '0;
                    end
                end
                MEM_WAIT: begin
                    if (hz_i_mem_ack) begin
                        state_d = RUN;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + 1'b1;
                        if (wait_q == WAIT_LAST)
                            state_d = HALT;
                    end
                end
                default: state_d = HALT;
            endcase
        end
    end

    // A redirect seen while memory holds the pipe is kept until the pipe moves again.
    always_comb begin
        pend_d = pend_q;
        cnt_d  = cnt_q;
        if (hz_i_ce) begin
            if (mem_stall && hz_i_change_pc)
                pend_d = 1'b1;
            else if (!mem_stall && state_q != HALT)
                pend_d = 1'b0;
            if (stall_v[3] && cnt_q != '1)
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        stall_v = 4'b0000;
        flush_v = 2'b00;
        if (!hz_i_ce || state_q == HALT || mem_stall)
            stall_v = 4'b1111;
        else if (redirect)
            flush_v = 2'b11;
        else if (load_use) begin
            stall_v = 4'b1100;
            flush_v = 2'b01;
        end
    end

    // Async reset must silence the control outputs immediately, not at the next edge.
    always_comb begin
        {hz_o_stall_fe, hz_o_stall_de, hz_o_stall_ex, hz_o_stall_mem} = hz_rst ? stall_v : 4'b0000;
        {hz_o_flush_de, hz_o_flush_ex} = hz_rst ? flush_v : 2'b00;
        hz_o_fwd_a     = hz_rst ? fwd_sel(hz_i_de_rs1_addr, hz_i_de_rs1_use) : 2'b00;
        hz_o_fwd_b     = hz_rst ? fwd_sel(hz_i_de_rs2_addr, hz_i_de_rs2_use) : 2'b00;
        hz_o_timeout   = (state_q == HALT);
        hz_o_stall_cnt = cnt_q;
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized check of hazard_unit against a behavioural pipeline-control model,
// preceded by directed scenarios for load-use, memory wait, timeout and redirect.
module tb_hazard_unit;

    localparam int AW = 5;
    localparam int CW = 4;
    localparam int MW = 15;

    logic hz_clk = 1'b0;
    logic hz_rst, ce;
    logic [AW-1:0] rs1, rs2, ex_rd, mem_rd, wb_rd;
    logic rs1_use, rs2_use, ex_we, ex_load, mem_we, wb_we, change_pc, mem_req, mem_ack;
    logic stall_fe, stall_de, stall_ex, stall_mem, flush_de, flush_ex, timeout;
    logic [1:0] fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    bit m_halt, m_wait, m_pend;
    int m_wcnt, m_scnt;

    always #5 hz_clk = ~hz_clk;

    hazard_unit #(.AWIDTH(AW), .CNT_WIDTH(CW), .MAX_WAIT(MW)) dut (
        .hz_clk(hz_clk), .hz_rst(hz_rst), .hz_i_ce(ce),
        .hz_i_de_rs1_addr(rs1), .hz_i_de_rs2_addr(rs2),
        .hz_i_de_rs1_use(rs1_use), .hz_i_de_rs2_use(rs2_use),
        .hz_i_ex_rd_addr(ex_rd), .hz_i_ex_rd_we(ex_we), .hz_i_ex_load(ex_load),
        .hz_i_mem_rd_addr(mem_rd), .hz_i_mem_rd_we(mem_we),
        .hz_i_wb_rd_addr(wb_rd), .hz_i_wb_rd_we(wb_we),
        .hz_i_change_pc(change_pc), .hz_i_mem_req(mem_req), .hz_i_mem_ack(mem_ack),
        .hz_o_stall_fe(stall_fe), .hz_o_stall_de(stall_de),
        .hz_o_stall_ex(stall_ex), .hz_o_stall_mem(stall_mem),
        .hz_o_flush_de(flush_de), .hz_o_flush_ex(flush_ex),
        .hz_o_fwd_a(fwd_a), .hz_o_fwd_b(fwd_b),
        .hz_o_timeout(timeout), .hz_o_stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [AW-1:0] a, input logic used);
        if (!used || a == 0) return 2'b00;
        if (ex_we && !ex_load && ex_rd == a) return 2'b01;
        if (mem_we && mem_rd == a) return 2'b10;
        if (wb_we && wb_rd == a) return 2'b11;
        return 2'b00;
    endfunction

    task automatic clr();
        ce = 1'b1; rs1 = '0; rs2 = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
        rs1_use = 0; rs2_use = 0; ex_we = 0; ex_load = 0; mem_we = 0; wb_we = 0;
        change_pc = 0; mem_req = 0; mem_ack = 0;
    endtask

    // Called just after a falling edge with inputs settled; checks, advances model, waits a cycle.
    task automatic cycle();
        logic [3:0] e_st;
        logic [1:0] e_fl;
        bit mstall, lu;
        #1;
        if (!hz_rst) begin
            m_halt = 0; m_wait = 0; m_pend = 0; m_wcnt = 0; m_scnt = 0;
        end
        mstall = mem_req && !mem_ack && !m_halt;
        lu = ex_load && ex_we && ex_rd != 0 &&
             ((rs1_use && rs1 == ex_rd) || (rs2_use && rs2 == ex_rd));
        e_st = 4'b0000;
        e_fl = 2'b00;
        if (!hz_rst) ;
        else if (!ce || m_halt || mstall) e_st = 4'b1111;
        else if (change_pc || m_pend) e_fl = 2'b11;
        else if (lu) begin e_st = 4'b1100; e_fl = 2'b01; end
        chk("stall", 32'({stall_fe, stall_de, stall_ex, stall_mem}), 32'(e_st));
        chk("flush", 32'({flush_de, flush_ex}), 32'(e_fl));
        chk("fwd_a", 32'(fwd_a), hz_rst ? 32'(fwd_ref(rs1, rs1_use)) : 32'd0);
        chk("fwd_b", 32'(fwd_b), hz_rst ? 32'(fwd_ref(rs2, rs2_use)) : 32'd0);
        chk("timeout", 32'(timeout), 32'(m_halt));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
        if (hz_rst && ce) begin
            if (e_st[3] && m_scnt < 2**CW - 1) m_scnt++;
            if (mstall && change_pc) m_pend = 1;
            else if (!mstall && !m_halt) m_pend = 0;
            if (!m_halt) begin
                if (!m_wait) begin
                    if (mstall) begin m_wait = 1; m_wcnt = 0; end
                end else if (mem_ack) begin
                    m_wait = 0; m_wcnt = 0;
                end else begin
                    m_wcnt++;
                    if (m_wcnt == MW) begin m_wait = 0; m_halt = 1; end
                end
            end
        end
        @(negedge hz_clk);
    endtask

    task automatic do_reset();
        clr();
        hz_rst = 1'b0;
        cycle();
        hz_rst = 1'b1;
    endtask

    initial begin
        clr();
        hz_rst = 1'b0;
        @(negedge hz_clk);
        cycle();
        cycle();
        hz_rst = 1'b1;
        cycle();

        // load-use on rs1, then the load has moved to MEM
        ex_load = 1; ex_we = 1; ex_rd = 5; rs1 = 5; rs1_use = 1;
        #1 chk("lu_stall", 32'({stall_fe, stall_de, flush_ex, stall_ex}), 32'b1110);
        cycle();
        clr(); mem_we = 1; mem_rd = 5; rs1 = 5; rs1_use = 1;
        #1 chk("lu_fwd_a", 32'(fwd_a), 32'b10);
        cycle();

        // three-cycle memory wait
        do_reset();
        mem_req = 1;
        repeat (3) begin
            #1 chk("mw_stall", 32'({stall_fe, stall_de, stall_ex, stall_mem}), 32'hf);
            cycle();
        end
        mem_ack = 1;
        #1 chk("mw_release", 32'({stall_fe, stall_de, stall_ex, stall_mem}), 32'h0);
        chk("mw_cnt", 32'(stall_cnt), 32'd3);
        cycle();
        clr();
        cycle();

        // redirect during memory stall is deferred
        do_reset();
        mem_req = 1; change_pc = 1;
        #1 chk("pend_noflush", 32'({flush_de, flush_ex}), 32'b00);
        cycle();
        change_pc = 0;
        cycle();
        mem_ack = 1;
        #1 chk("pend_flush", 32'({flush_de, flush_ex}), 32'b11);
        cycle();
        clr();
        #1 chk("pend_cleared", 32'({flush_de, flush_ex}), 32'b00);
        cycle();

        // watchdog timeout, saturating counter, reset recovery
        do_reset();
        mem_req = 1;
        repeat (MW) cycle();
        #1 chk("pre_timeout", 32'(timeout), 32'd0);
        cycle();
        #1 chk("timeout", 32'(timeout), 32'd1);
        cycle();
        mem_req = 0; change_pc = 1;
        repeat (4) begin
            #1 chk("halt_stall", 32'({stall_fe, stall_de, stall_ex, stall_mem, flush_de, flush_ex}), 32'b111100);
            cycle();
        end
        chk("cnt_sat", 32'(stall_cnt), 32'd15);
        do_reset();
        #1 chk("after_reset_flush", 32'({flush_de, flush_ex, timeout}), 32'b000);
        cycle();

        // forwarding priority and x0
        clr();
        ex_we = 1; mem_we = 1; wb_we = 1; ex_rd = 7; mem_rd = 7; wb_rd = 7;
        rs2 = 7; rs2_use = 1;
        #1 chk("fwd_b_ex", 32'(fwd_b), 32'b01);
        cycle();
        ex_rd = 0; mem_rd = 0; wb_rd = 0; rs2 = 0;
        #1 chk("fwd_b_x0", 32'(fwd_b), 32'b00);
        cycle();

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            hz_rst    = ($urandom_range(0, 79) != 0);
            ce        = ($urandom_range(0, 9) != 0);
            rs1       = AW'($urandom_range(0, 3));
            rs2       = AW'($urandom_range(0, 3));
            ex_rd     = AW'($urandom_range(0, 3));
            mem_rd    = AW'($urandom_range(0, 3));
            wb_rd     = AW'($urandom_range(0, 3));
            rs1_use   = 1'($urandom);
            rs2_use   = 1'($urandom);
            ex_we     = 1'($urandom);
            ex_load   = 1'($urandom);
            mem_we    = 1'($urandom);
            wb_we     = 1'($urandom);
            change_pc = ($urandom_range(0, 7) == 0);
            mem_req   = 1'($urandom);
            mem_ack   = ($urandom_range(0, 4) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter AWIDTH, default 5, register-address width.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, stall-counter width.
REQ-003 SHALL have parameter MAX_WAIT, default 15, memory-wait cycles before timeout.
REQ-004 SHALL have port hz_clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port hz_rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port hz_i_ce  input  1  global enable.
REQ-007 SHALL have ports hz_i_de_rs1_addr / hz_i_de_rs2_addr  input  AWIDTH each  decode-stage source registers.
REQ-008 SHALL have ports hz_i_de_rs1_use / hz_i_de_rs2_use  input  1 each  source actually read.
REQ-009 SHALL have ports hz_i_ex_rd_addr  input  AWIDTH, hz_i_ex_rd_we  input  1, hz_i_ex_load  input  1  execute-stage destination.
REQ-010 SHALL have ports hz_i_mem_rd_addr  input  AWIDTH, hz_i_mem_rd_we  input  1  memory-stage destination.
REQ-011 SHALL have ports hz_i_wb_rd_addr  input  AWIDTH, hz_i_wb_rd_we  input  1  writeback-stage destination.
REQ-012 SHALL have port hz_i_change_pc  input  1  taken branch/jump resolved in execute.
REQ-013 SHALL have ports hz_i_mem_req / hz_i_mem_ack  input  1 each  data-memory request/acknowledge.
REQ-014 SHALL have ports hz_o_stall_fe, hz_o_stall_de, hz_o_stall_ex, hz_o_stall_mem  output  1 each  per-stage hold.
REQ-015 SHALL have ports hz_o_flush_de, hz_o_flush_ex  output  1 each  insert bubble into decode / execute.
REQ-016 SHALL have ports hz_o_fwd_a / hz_o_fwd_b  output  2 each  operand source: 00 regfile, 01 EX, 10 MEM, 11 WB.
REQ-017 SHALL have ports hz_o_timeout  output  1 and hz_o_stall_cnt  output  CNT_WIDTH.

Function
REQ-018 SHALL implement FSM states RUN, MEM_WAIT, HALT.
REQ-019 RUN->MEM_WAIT when hz_i_mem_req=1 and hz_i_mem_ack=0; MEM_WAIT->RUN on hz_i_mem_ack=1; MEM_WAIT->HALT when wait counter reaches MAX_WAIT without ack; HALT exits only by reset.
REQ-020 Memory stall (combinational): mem_req&!mem_ack in RUN or MEM_WAIT SHALL assert all four stalls the same cycle; flushes 0.
REQ-021 Wait counter SHALL clear on entering MEM_WAIT, increment each MEM_WAIT cycle, clear on return to RUN.
REQ-022 HALT SHALL assert all four stalls and hz_o_timeout continuously; flushes 0.
REQ-023 Load-use hazard = ex_load & ex_rd_we & ex_rd!=0 & ((rs1_use & rs1==ex_rd) | (rs2_use & rs2==ex_rd)); SHALL assert stall_fe, stall_de, flush_ex for that cycle only.
REQ-024 hz_i_change_pc=1 SHALL assert flush_de and flush_ex for one cycle, no stalls.
REQ-025 Priority: HALT > memory stall > change_pc > load-use; change_pc overrides a simultaneous load-use.
REQ-026 change_pc arriving during memory stall SHALL be latched pending and applied (flush_de, flush_ex) on the first non-stalled cycle, then cleared.
REQ-027 Forwarding per operand, youngest first: EX match (rd_we, rd!=0, addr equal, not load) ->01; else MEM match ->10; else WB match ->11; else 00; unused operand ->00.
REQ-028 Register x0 SHALL never forward or cause a hazard.
REQ-029 hz_o_stall_cnt SHALL increment each cycle hz_o_stall_fe=1, saturating at all-ones.
REQ-030 hz_i_ce=0 SHALL assert all four stalls, deassert flushes, freeze FSM, counters and pending flag.

Reset
REQ-031 hz_rst=0 SHALL immediately force state RUN, wait counter 0, pending flag 0, hz_o_stall_cnt 0, hz_o_timeout 0.
REQ-032 During reset all stall, flush and forward outputs SHALL be 0.
REQ-033 Reset mid-MEM_WAIT or in HALT SHALL return to RUN with no residual pending flush.

Verification
REQ-034 ex_load=1, ex_rd=5, rs1=5, rs1_use=1 -> one cycle stall_fe=stall_de=flush_ex=1; next cycle with load in MEM -> fwd_a=10.
REQ-035 mem_req=1, ack low 3 cycles -> all stalls 1 for 3 cycles, stall_cnt=3; ack high -> RUN, stalls 0.
REQ-036 mem_req=1, ack never -> after 15 wait cycles hz_o_timeout=1, stalls stay 1; reset clears.
REQ-037 change_pc=1 during memory stall -> no flush while stalled; flush_de=flush_ex=1 on first cycle after ack.
REQ-038 rs2=7 matching EX (non-load), MEM and WB simultaneously -> fwd_b=01; rs2=0 with all matching -> fwd_b=00.
